// File: rtl/mips_mem_pkg.sv
// Shared encodings for the load/store path: access sizes, LSU states and memory depth.
package mips_mem_pkg;

    localparam int MEM_WORDS_DFLT = 128;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extract/extend and store read-modify-write merge.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    always_comb begin
        shamt     = {offset, 3'b000};
        shifted   = old_word >> shamt;
        rdata     = old_word;
        lane_mask = '1;
        lane_data = wdata;
        case (size)
            SZ_BYTE: begin
                rdata     = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00ff << shamt;
                lane_data = {24'b0, wdata[7:0]} << shamt;
            end
            SZ_HALF: begin
                rdata     = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_ffff << shamt;
                lane_data = {16'b0, wdata[15:0]} << shamt;
            end
            default: ;
        endcase
        // Full-word accesses take the mask of all ones, so merged degenerates to wdata.
        merged = (old_word & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store initiator for a word-wide data memory; sub-word stores use read-modify-write.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DFLT,
    parameter int IDX_W     = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state_reg;
    logic        write_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] old_word_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        req_err;
    logic [31:0] old_word_sel;
    logic [31:0] load_rdata;
    logic [31:0] merged_word;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'd3)
            req_err = 1'b1;
        else if (req_size == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_addr[31:IDX_W+2] != '0 ||
            {1'b0, req_addr[IDX_W+1:2]} >= (IDX_W+1)'(MEM_WORDS))
            req_err = 1'b1;
    end

    // Loads extract straight from the memory bus in READ; stores merge against the captured word.
    assign old_word_sel = (state_reg == ST_READ) ? mem_read_data : old_word_reg;

    lsu_lane_align u_align (
        .old_word (old_word_sel),
        .wdata    (wdata_reg),
        .offset   (addr_reg[1:0]),
        .size     (size_reg),
        .sign_ext (signed_reg),
        .rdata    (load_rdata),
        .merged   (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            write_reg    <= 1'b0;
            size_reg     <= 2'b00;
            signed_reg   <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            old_word_reg <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_reg  <= req_write;
                        size_reg   <= req_size;
                        signed_reg <= req_signed;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        rdata_reg  <= '0;
                        err_reg    <= req_err;
                        if (req_err)
                            state_reg <= ST_RESP;
                        else if (req_write && req_size == SZ_WORD)
                            state_reg <= ST_WRITE;
                        else
                            state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_word_reg <= mem_read_data;
                    if (write_reg) begin
                        state_reg <= ST_WRITE;
                    end else begin
                        rdata_reg <= load_rdata;
                        state_reg <= ST_RESP;
                    end
                end
                ST_WRITE: state_reg <= ST_RESP;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready      = (state_reg == ST_IDLE);
    assign resp_valid     = (state_reg == ST_RESP);
    assign resp_err       = err_reg;
    assign resp_rdata     = rdata_reg;
    assign mem_read       = (state_reg == ST_READ);
    assign mem_write      = (state_reg == ST_WRITE);
    assign mem_addr       = {2'b00, addr_reg[31:2]};
    assign mem_write_data = (state_reg == ST_WRITE) ? merged_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 128-word behavioural data memory attached.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    load_store_unit #(.MEM_WORDS(128), .IDX_W(7)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:127];
    initial for (int i = 0; i < 128; i++) mem[i] = '0;
    assign mem_read_data = mem[mem_addr[6:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[6:0]] <= mem_write_data;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t sq[$];
    wr_t   wq[$];
    int    n_vec = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_resp = 0;
    int    n_tracked = 0;
    bit    access_seen = 0;
    bit    skip_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        n_vec++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none", nm);
    endtask

    // Monitor: one line per completed transaction, plus write-port and handshake checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read || mem_write) begin
                access_seen = 1;
                chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
                chk("ready_low_busy", {31'b0, req_ready}, 32'd0);
            end
            if (mem_write && !skip_wr) begin
                if (wq.size() == 0) note_fail("unexpected_write");
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_write_data, w.data);
                end
            end
            if (resp_valid) begin
                chk("ready_low_resp", {31'b0, req_ready}, 32'd0);
                if (sq.size() == 0) note_fail("unexpected_resp");
                else begin
                    resp_t r;
                    r = sq.pop_front();
                    $display("resp #%0d: err=%0b rdata=0x%08h cyc=%0d", n_resp, resp_err, resp_rdata, cyc);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, r.err});
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("resp_latency", cyc, r.cyc);
                    chk("mem_access", {31'b0, access_seen}, {31'b0, ~r.err});
                end
                access_seen = 0;
                n_resp++;
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic e_err, input logic [31:0] e_rdata, input int lat,
                         input logic e_wr, input logic [31:0] e_wdata,
                         input logic hold, input logic track);
        int n;
        @(negedge clk);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            note_fail("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        if (track) begin
            sq.push_back('{e_err, e_rdata, cyc + lat});
            n_tracked++;
            if (e_wr) wq.push_back('{{2'b00, a[31:2]}, e_wdata});
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //      w     size     sg    addr           wdata          err   rdata          lat wr    wdata          hold  track
        issue(1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          2, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b1, SZ_BYTE, 1'b0, 32'h0000_0012, 32'h0000_0055, 1'b0, 32'h0,          3, 1'b1, 32'hDE55_BEEF, 1'b0, 1'b1);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_0055, 2, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FFDE, 2, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'hFFFF_FFEF, 2, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b1, SZ_HALF, 1'b0, 32'h0000_0016, 32'h0000_8001, 1'b0, 32'h0,          3, 1'b1, 32'h8001_0000, 1'b0, 1'b1);
        issue(1'b0, SZ_HALF, 1'b1, 32'h0000_0016, 32'h0,         1'b0, 32'hFFFF_8001, 2, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, SZ_HALF, 1'b0, 32'h0000_0016, 32'h0,         1'b0, 32'h0000_8001, 2, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, SZ_HALF, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_BEEF, 2, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'h0,          1, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, SZ_HALF, 1'b0, 32'h0000_0021, 32'h0,         1'b1, 32'h0,          1, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, 2'd3,    1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'h0,          1, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'h0,          1, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b1, SZ_WORD, 1'b0, 32'h0000_0200, 32'h1234_5678, 1'b1, 32'h0,          1, 1'b0, 32'h0,         1'b0, 1'b1);
        issue(1'b0, SZ_WORD, 1'b0, 32'h0000_01FC, 32'h0,         1'b0, 32'h0,          2, 1'b0, 32'h0,         1'b0, 1'b1);

        // Reset while the sub-word store sits in WRITE: nothing may commit or respond.
        skip_wr = 1;
        issue(1'b1, SZ_BYTE, 1'b0, 32'h0000_0012, 32'h0000_00AA, 1'b0, 32'h0, 3, 1'b0, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (!mem_write && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_write", {31'b0, mem_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        access_seen = 0;
        skip_wr = 0;
        rst_n = 1'b1;
        issue(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDE55_BEEF, 2, 1'b0, 32'h0, 1'b0, 1'b1);

        // Eight loads with req_valid held high throughout.
        for (int k = 0; k < 8; k++) begin
            if (k[0])
                issue(1'b0, SZ_WORD, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h8001_0000, 2, 1'b0, 32'h0, (k != 7), 1'b1);
            else
                issue(1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDE55_BEEF, 2, 1'b0, 32'h0, (k != 7), 1'b1);
        end

        n = 0;
        while ((sq.size() != 0 || wq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        chk("pending_resp", sq.size(), 32'd0);
        chk("pending_write", wq.size(), 32'd0);
        chk("resp_count", n_resp, n_tracked);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
